// File: rtl/fsub_pipe_if.sv
// fsub_pipe_if: operand/result handshake bundle for fsub_pipe.
// master drives operands and out_ready; slave (the subtractor) drives in_ready/out_valid/y.
interface fsub_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  modport master (
    output in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, x1, x2, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/fsub_pipe.sv
// fsub_pipe: two-stage single-precision subtractor y = x1 - x2 with valid/ready
// on both sides and full backpressure. Two guard bits, no sticky, denormals as zero.
// Optional NaN/Inf handling is enabled by defining FSUB_PIPE_SPECIAL_EN.
module fsub_pipe (
  input  logic        clk,
  input  logic        rst,
  fsub_pipe_if.slave  bus
);
  // pipeline control
  logic        r_s1_valid;
  logic        r_out_valid;
  logic [31:0] r_y;
  logic        w_adv2;
  logic        w_adv1;

  assign w_adv2        = !r_out_valid || bus.out_ready;
  assign w_adv1        = w_adv2;
  assign bus.in_ready  = !r_s1_valid || w_adv1;
  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;

  // stage 1: negate subtrahend, order by magnitude, align the smaller mantissa
  logic [31:0] w_x2n;
  logic        w_x1_gt;
  logic [31:0] w_big;
  logic [31:0] w_small;
  logic [7:0]  w_ediff;
  logic [26:0] w_mia;
  logic        w_sub;
  logic        w_pass;

  assign w_x2n   = {~bus.x2[31], bus.x2[30:0]};
  assign w_x1_gt = bus.x1[30:0] > bus.x2[30:0];
  assign w_big   = w_x1_gt ? bus.x1 : w_x2n;
  assign w_small = w_x1_gt ? w_x2n  : bus.x1;
  assign w_ediff = w_big[30:23] - w_small[30:23];
  assign w_mia   = {2'b01, w_small[22:0], 2'b00} >> w_ediff[4:0];
  assign w_sub   = bus.x1[31] ^ w_x2n[31];
  assign w_pass  = (w_small[30:23] == 8'd0) || (w_ediff >= 8'd32);

  logic        r_ssup;
  logic [7:0]  r_esup;
  logic [22:0] r_msup;
  logic [26:0] r_mia;
  logic        r_sub;
  logic        r_pass;

`ifdef FSUB_PIPE_SPECIAL_EN
  logic        w_nan1, w_nan2, w_inf1, w_inf2;
  logic        w_spec;
  logic [31:0] w_spec_val;
  logic        r_spec;
  logic [31:0] r_spec_val;

  assign w_nan1 = (bus.x1[30:23] == 8'hFF) && (bus.x1[22:0] != 23'd0);
  assign w_nan2 = (bus.x2[30:23] == 8'hFF) && (bus.x2[22:0] != 23'd0);
  assign w_inf1 = (bus.x1[30:23] == 8'hFF) && (bus.x1[22:0] == 23'd0);
  assign w_inf2 = (bus.x2[30:23] == 8'hFF) && (bus.x2[22:0] == 23'd0);

  // classify NaN/Inf operands; these results bypass the arithmetic path
  always_comb begin
    w_spec     = 1'b0;
    w_spec_val = '0;
    if (w_nan1 || w_nan2) begin
      w_spec     = 1'b1;
      w_spec_val = 32'h7FC00000;
    end else if (w_inf1 && w_inf2 && (bus.x1[31] == bus.x2[31])) begin
      w_spec     = 1'b1;
      w_spec_val = 32'h7FC00000;
    end else if (w_inf1) begin
      w_spec     = 1'b1;
      w_spec_val = bus.x1;
    end else if (w_inf2) begin
      w_spec     = 1'b1;
      w_spec_val = w_x2n;
    end
  end

  // stage 1 special-case register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spec     <= 1'b0;
      r_spec_val <= '0;
    end else if (bus.in_valid && bus.in_ready) begin
      r_spec     <= w_spec;
      r_spec_val <= w_spec_val;
    end
  end
`endif

  // stage 1 register: loads on an input transfer, empties when its data moves on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_ssup     <= 1'b0;
      r_esup     <= '0;
      r_msup     <= '0;
      r_mia      <= '0;
      r_sub      <= 1'b0;
      r_pass     <= 1'b0;
    end else if (bus.in_ready) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_ssup <= w_big[31];
        r_esup <= w_big[30:23];
        r_msup <= w_big[22:0];
        r_mia  <= w_mia;
        r_sub  <= w_sub;
        r_pass <= w_pass;
      end
    end
  end

  // stage 2: add/subtract, normalize, round half-up on the guard bit
  logic [26:0] w_calc;
  logic [4:0]  w_lz;
  logic [26:0] w_shift;
  logic        w_round;
  logic [22:0] w_man;
  logic [8:0]  w_ey;
  logic [31:0] w_y;
  logic        w_unused;

  assign w_calc  = r_sub ? ({2'b01, r_msup, 2'b00} - r_mia)
                         : ({2'b01, r_msup, 2'b00} + r_mia);
  assign w_shift = w_calc << w_lz;
  assign w_round = &w_shift[25:2];
  assign w_man   = w_shift[25:3] + {22'd0, w_shift[2]};
  assign w_ey    = {1'b0, r_esup} - {4'd0, w_lz} + 9'd1 + {8'd0, w_round};
  assign w_unused = ^{w_shift[26], w_shift[1:0], w_small[31]};

  // leading-zero count of the 27-bit sum (27 when the sum is zero)
  always_comb begin
    w_lz = 5'd27;
    for (int unsigned i = 0; i < 27; i++) begin
      if (w_calc[i]) w_lz = 5'(26 - i);
    end
  end

  // result selection including pass-through and zero/underflow/overflow cases
  always_comb begin
    w_y = '0;
    if (r_pass)
      w_y = {r_ssup, r_esup, r_msup};
    else if (w_calc == 27'd0)
      w_y = 32'h00000000;
    else if (w_ey[8])
      w_y = {r_ssup, 31'd0};
    else if (w_ey[7:0] == 8'hFF)
      w_y = {r_ssup, 8'hFF, 23'd0};
    else
      w_y = {r_ssup, w_ey[7:0], w_man};
`ifdef FSUB_PIPE_SPECIAL_EN
    if (r_spec) w_y = r_spec_val;
`endif
  end

  // stage 2 output register: y only changes when a new result moves in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) r_y <= w_y;
    end
  end
endmodule

// File: tb/tb_fsub_pipe.sv
// tb_fsub_pipe: directed vectors into a scoreboard queue; a negedge monitor pops
// and compares on every output transfer and checks y stability under stall.
module tb_fsub_pipe;
  logic clk = 1'b0;
  logic rst;
  fsub_pipe_if bus ();

  fsub_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          lat_exact = 1'b1;
  bit          hold_pending = 1'b0;
  logic [31:0] hold_y;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // monitor: scoreboard compare on each output transfer, plus hold-stability check
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (hold_pending) begin
        checks++;
        if (!(bus.out_valid === 1'b1 && bus.y === hold_y)) begin
          errors++;
          $display("FAIL hold: got valid=%0b y=%08h expected valid=1 y=%08h",
                   bus.out_valid, bus.y, hold_y);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got y=%08h expected no output", bus.y);
        end else begin
          e = q.pop_front();
          if (bus.y !== e.y) begin
            errors++;
            $display("FAIL result: got %08h expected %08h", bus.y, e.y);
          end
          if (lat_exact) begin
            checks++;
            if (cyc - e.cyc != 2) begin
              errors++;
              $display("FAIL latency: got %0d expected 2", cyc - e.cyc);
            end
          end
        end
      end
      hold_pending = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
      hold_y       = bus.y;
    end else begin
      hold_pending = 1'b0;
    end
  end

  // drive one operand pair; push the expectation at the cycle it is accepted
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, output int waits);
    bit acc;
    acc   = 1'b0;
    waits = 0;
    bus.x1       = a;
    bus.x2       = b;
    bus.in_valid = 1'b1;
    while (!acc && waits < 200) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        q.push_back('{exp, cyc});
        acc = 1'b1;
      end else begin
        waits++;
        @(posedge clk);
        #1;
      end
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected 1", waits);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.x1       = '0;
    bus.x2       = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  localparam int NV = 13;
  logic [31:0] vx1 [NV] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                            32'h3F800000, 32'h7F7FFFFF, 32'h3FC00000, 32'h3F800000,
                            32'h3F800000, 32'h80800001, 32'h C0400000, 32'h3F800000,
                            32'h7F800000};
  logic [31:0] vx2 [NV] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h2B800000,
                            32'h00000001, 32'hFF7FFFFF, 32'h3E800000, 32'h33000000,
                            32'hB3800000, 32'h80800000, 32'h3F800000, 32'hFF800000,
                            32'h7F800000};
`ifdef FSUB_PIPE_SPECIAL_EN
  logic [31:0] vy  [NV] = '{32'h40000000, 32'hC0000000, 32'h00000000, 32'h3F800000,
                            32'h3F800000, 32'h7F800000, 32'h3FA00000, 32'h3F800000,
                            32'h3F800001, 32'h80000000, 32'hC0800000, 32'h7F800000,
                            32'h7FC00000};
`else
  logic [31:0] vy  [NV] = '{32'h40000000, 32'hC0000000, 32'h00000000, 32'h3F800000,
                            32'h3F800000, 32'h7F800000, 32'h3FA00000, 32'h3F800000,
                            32'h3F800001, 32'h80000000, 32'hC0800000, 32'h7F800000,
                            32'h00000000};
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w0, w1, w2;
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd1 - 32'd1);
    chk("reset_y", bus.y, 32'h00000000);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single op, exact two-cycle latency
    send(32'h40400000, 32'h3F800000, 32'h40000000, w);
    idle();
    drain();

    // back-to-back directed vectors with out_ready high: no bubbles
    for (int i = 0; i < NV; i++) begin
      send(vx1[i], vx2[i], vy[i], w);
      chk("no_stall_in_ready", 32'(w), 32'd0);
    end
    idle();
    drain();

`ifdef FSUB_PIPE_SPECIAL_EN
    send(32'h3F800000, 32'h7F800001, 32'h7FC00000, w);
`else
    send(32'h3F800000, 32'h7F800001, 32'hFF800001, w);
`endif
    idle();
    drain();

    // backpressure: two accepts fill the pipe, the third waits
    lat_exact     = 1'b0;
    bus.out_ready = 1'b0;
    send(32'h40000000, 32'h3F800000, 32'h3F800000, w0);
    send(32'h3FC00000, 32'h3E800000, 32'h3FA00000, w1);
    chk("bp_first_accept_waits", 32'(w0), 32'd0);
    chk("bp_second_accept_waits", 32'(w1), 32'd0);
    fork
      send(32'h40400000, 32'h3F800000, 32'h40000000, w2);
      begin
        @(negedge clk);
        chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp_y_first", bus.y, 32'h3F800000);
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    chk("bp_third_waited", {31'd0, (w2 > 0)}, 32'd1);
    idle();
    drain();

    // asynchronous reset with a full, stalled pipe
    bus.out_ready = 1'b0;
    send(32'h40400000, 32'h3F800000, 32'h40000000, w);
    send(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, w);
    idle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_no_stale", {31'd0, bus.out_valid}, 32'd0);

    // pipeline recovers after reset
    lat_exact = 1'b1;
    send(32'h3F800000, 32'h40400000, 32'hC0000000, w);
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
